// File: rtl/mux_pkg.sv
// Shared types for the scanning N:1 LED/bus multiplexer.
// Holds the control FSM encoding and the mode-select constants.
package mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_nx1_scan_dwell_counter.sv
// Dwell timer for SCAN mode: counts 0..DWELL-1 while enabled.
// tick pulses on the terminal count; clr or reset returns it to zero.
module dwell_counter #(
  parameter int DWELL = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_last;

  assign at_last = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && !clr && at_last;

endmodule

// File: rtl/mux_nx1_scan.sv
// N:1 W-bit registered multiplexer with MANUAL select and auto SCAN,
// hold/freeze control and a one-cycle select-change strobe.
module mux_nx1_scan
  import mux_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int W     = 8,
  parameter  int DWELL = 16,
  localparam int SELW  = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  in_data,
  input  logic [SELW-1:0] sel_in,
  input  logic            mode,
  input  logic            hold,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_sel,
  output logic            out_valid,
  output logic            sel_chg
);

  localparam logic [SELW:0]   N_LIM = (SELW + 1)'(N);
  localparam logic [SELW-1:0] LAST  = SELW'(N - 1);

  state_e          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d, sel_nxt;
  logic [W-1:0]    data_q, data_d, mux_data;
  logic            valid_q, valid_d;
  logic            chg_q;
  logic            sel_ok;
  logic            scanning;
  logic            cnt_en, cnt_clr, tick;

  assign sel_ok   = ({1'b0, sel_in} < N_LIM);
  assign sel_nxt  = (sel_q == LAST) ? '0 : sel_q + 1'b1;
  assign scanning = (state_q == SCAN) && (mode == MODE_SCAN);
  assign cnt_en   = !hold && scanning;
  assign cnt_clr  = !hold && !scanning;

  dwell_counter #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk (clk),
    .rst (rst),
    .en  (cnt_en),
    .clr (cnt_clr),
    .tick(tick)
  );

  // A mode change edge only switches state; the select is left alone.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    if (!hold) begin
      unique case (state_q)
        IDLE: begin
          valid_d = 1'b1;
          if (mode == MODE_SCAN) begin
            state_d = SCAN;
          end else begin
            state_d = MANUAL;
            if (sel_ok) sel_d = sel_in;
          end
        end
        MANUAL: begin
          if (mode == MODE_SCAN) begin
            state_d = SCAN;
          end else if (sel_ok) begin
            sel_d = sel_in;
          end
        end
        SCAN: begin
          if (mode == MODE_MANUAL) begin
            state_d = MANUAL;
          end else if (tick) begin
            sel_d = sel_nxt;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    mux_data = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_d == SELW'(k)) mux_data = in_data[k*W +: W];
    end
  end

  assign data_d = hold ? data_q : mux_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      chg_q   <= (sel_d != sel_q);
    end
  end

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;
  assign sel_chg   = chg_q;

endmodule
